fpudivd_iter: RTL and testbench

- Iterative radix-2 IEEE double-precision divider. It is the inverse-operation companion to the FPU multiply datapath.
- Accepts A/B with a start pulse, computes one quotient bit per cycle, then rounds in one cycle.
- Returns a result plus exception raise bits through a done pulse.
- Sits beside the multiplier on the FPU issue port. It is a shared, non-pipelined unit, so only one operation is in flight at a time.

---
 rtl/fpudivd_iter.sv | 230 +++++++++++++++++++++++
 tb/tb_fpudivd_iter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpudivd_iter.sv
// Iterative radix-2 restoring divider for IEEE doubles: one quotient bit per cycle, then a single rounding cycle.
// Subnormal operands are read as zero, and tiny results are flushed to zero.
module fpudivd_iter #(
    parameter int          QBITS = 55,
    parameter logic [63:0] QNAN  = 64'h7FF8000000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  rmode,
    output logic        busy,
    output logic        done,
    output logic [63:0] res,
    output logic [4:0]  raise
);

    typedef enum logic [1:0] {IDLE, SPEC, DIV, RND} state_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } opClass_t;

    function automatic opClass_t classify(input logic [63:0] x);
        opClass_t c;
        c.nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'b0);
        c.snan = c.nan && !x[51];
        c.inf  = (x[62:52] == 11'h7FF) && (x[51:0] == 52'b0);
        c.zero = (x[62:52] == 11'h000);
        return c;
    endfunction

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [10:0]      ea_q, ea_d, eb_q, eb_d;
    logic [52:0]      mb_q, mb_d;
    logic [53:0]      rem_q, rem_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2:0]       rmode_q, rmode_d;
    opClass_t         aCls_q, aCls_d, bCls_q, bCls_d;
    logic             done_q, done_d;
    logic [63:0]      res_q, res_d;
    logic [4:0]       raise_q, raise_d;

    opClass_t classA, classB;
    logic     isSpecial;

    assign classA    = classify(A);
    assign classB    = classify(B);
    assign isSpecial = classA.nan | classA.inf | classA.zero |
                       classB.nan | classB.inf | classB.zero;

    // Special-operand result, evaluated from the classes captured at start.
    logic [63:0] specRes;
    logic [4:0]  specRaise;
    logic        zeroZero, infInf;

    always_comb begin
        specRes   = {sign_q, 63'b0};
        specRaise = 5'b0;
        zeroZero  = aCls_q.zero & bCls_q.zero;
        infInf    = aCls_q.inf & bCls_q.inf;
        if (aCls_q.nan | bCls_q.nan | zeroZero | infInf) begin
            specRes   = QNAN;
            specRaise = {4'b0, aCls_q.snan | bCls_q.snan | zeroZero | infInf};
        end else if (bCls_q.zero & !aCls_q.inf) begin
            specRes   = {sign_q, 11'h7FF, 52'b0};
            specRaise = 5'b00010;
        end else if (aCls_q.inf) begin
            specRes   = {sign_q, 11'h7FF, 52'b0};
        end
    end

    // One restoring step: the remainder never exceeds twice the divisor, so 54 bits suffice.
    logic [54:0] diff;
    logic        qBit;
    logic [53:0] remStep;

    always_comb begin
        diff    = {1'b0, rem_q} - {2'b0, mb_q};
        qBit    = ~diff[54];
        remStep = qBit ? diff[53:0] : rem_q;
    end

    // Rounding; the 52-bit fraction wraps to zero exactly when the increment carries out.
    logic signed [12:0] expBase, expAdj, expFin;
    logic [51:0]        fracRaw, fracFin;
    logic               guard, sticky, incr, carry, inexact;
    logic [63:0]        rndRes;
    logic [4:0]         rndRaise;

    always_comb begin
        expBase = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 13'sd1023;
        if (q_q[QBITS-1]) begin
            fracRaw = q_q[QBITS-2:QBITS-53];
            guard   = q_q[QBITS-54];
            sticky  = q_q[QBITS-55] | (|rem_q);
            expAdj  = expBase;
        end else begin
            fracRaw = q_q[QBITS-3:QBITS-54];
            guard   = q_q[QBITS-55];
            sticky  = |rem_q;
            expAdj  = expBase - 13'sd1;
        end
        case (rmode_q)
            3'd1:       incr = guard;
            3'd2, 3'd7: incr = guard & (sticky | fracRaw[0]);
            3'd3:       incr = ~sign_q & (guard | sticky);
            3'd4:       incr = sign_q & (guard | sticky);
            3'd5:       incr = guard | sticky;
            default:    incr = 1'b0;
        endcase
        carry   = incr & (&fracRaw);
        fracFin = fracRaw + {51'b0, incr};
        expFin  = carry ? expAdj + 13'sd1 : expAdj;
        inexact = guard | sticky;
        if (expFin >= 13'sd2047) begin
            rndRes   = {sign_q, 11'h7FF, 52'b0};
            rndRaise = 5'b10100;
        end else if (expFin <= 13'sd0) begin
            rndRes   = {sign_q, 63'b0};
            rndRaise = 5'b11000;
        end else begin
            rndRes   = {sign_q, expFin[10:0], fracFin};
            rndRaise = {inexact, 4'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        rmode_d = rmode_q;
        aCls_d  = aCls_q;
        bCls_d  = bCls_q;
        done_d  = 1'b0;
        res_d   = res_q;
        raise_d = raise_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = A[63] ^ B[63];
                    ea_d    = A[62:52];
                    eb_d    = B[62:52];
                    mb_d    = {1'b1, B[51:0]};
                    rem_d   = {2'b01, A[51:0]};
                    q_d     = '0;
                    cnt_d   = 6'd0;
                    rmode_d = rmode;
                    aCls_d  = classA;
                    bCls_d  = classB;
                    res_d   = 64'b0;
                    raise_d = 5'b0;
                    state_d = isSpecial ? SPEC : DIV;
                end
            end
            SPEC: begin
                res_d   = specRes;
                raise_d = specRaise;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DIV: begin
                rem_d = {remStep[52:0], 1'b0};
                q_d   = {q_q[QBITS-2:0], qBit};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(QBITS - 1)) begin
                    state_d = RND;
                end
            end
            RND: begin
                res_d   = rndRes;
                raise_d = rndRaise;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 11'b0;
            eb_q    <= 11'b0;
            mb_q    <= 53'b0;
            rem_q   <= 54'b0;
            q_q     <= '0;
            cnt_q   <= 6'd0;
            rmode_q <= 3'd0;
            aCls_q  <= '0;
            bCls_q  <= '0;
            done_q  <= 1'b0;
            res_q   <= 64'b0;
            raise_q <= 5'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            rmode_q <= rmode_d;
            aCls_q  <= aCls_d;
            bCls_q  <= bCls_d;
            done_q  <= done_d;
            res_q   <= res_d;
            raise_q <= raise_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign res   = res_q;
    assign raise = raise_q;

endmodule

// File: tb/tb_fpudivd_iter.sv
// Bench for fpudivd_iter: an arithmetic reference model with cycle-level timing, compared on every negedge,
// plus directed vectors that carry hand-computed results.
module tb_fpudivd_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] A, B;
    logic [2:0]  rmode;
    logic        busy, done;
    logic [63:0] res;
    logic [4:0]  raise;

    int checks = 0;
    int errors = 0;

    fpudivd_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .rmode (rmode),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .raise (raise)
    );

    always #5 clk = ~clk;

    // Reference quotient from exact integer division of the scaled significands.
    function automatic void modelDiv(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                                     output logic [63:0] r, output logic [4:0] fl, output bit special);
        logic         s;
        logic [10:0]  ea, eb;
        bit           an, bn, asn, bsn, ai, bi, az, bz, g, st, inc;
        logic [127:0] num, den, qv, rv;
        logic [63:0]  mant;
        int           e;
        s   = a[63] ^ b[63];
        ea  = a[62:52];
        eb  = b[62:52];
        an  = (ea == 11'h7FF) && (a[51:0] != 52'b0);
        bn  = (eb == 11'h7FF) && (b[51:0] != 52'b0);
        asn = an && !a[51];
        bsn = bn && !b[51];
        ai  = (ea == 11'h7FF) && (a[51:0] == 52'b0);
        bi  = (eb == 11'h7FF) && (b[51:0] == 52'b0);
        az  = (ea == 11'h000);
        bz  = (eb == 11'h000);
        special = an || bn || ai || bi || az || bz;
        r  = 64'b0;
        fl = 5'b0;
        if (special) begin
            if (an || bn || (az && bz) || (ai && bi)) begin
                r  = 64'h7FF8000000000000;
                fl = {4'b0, asn || bsn || (az && bz) || (ai && bi)};
            end else if (ai) begin
                r = {s, 11'h7FF, 52'b0};
            end else if (bz) begin
                r  = {s, 11'h7FF, 52'b0};
                fl = 5'b00010;
            end else begin
                r = {s, 63'b0};
            end
        end else begin
            num = {75'b0, 1'b1, a[51:0]} << 54;
            den = {75'b0, 1'b1, b[51:0]};
            qv  = num / den;
            rv  = num % den;
            e   = int'(ea) - int'(eb) + 1023;
            if (qv[54]) begin
                mant = {11'b0, qv[54:2]};
                g    = qv[1];
                st   = qv[0] || (rv != 128'b0);
            end else begin
                mant = {11'b0, qv[53:1]};
                g    = qv[0];
                st   = (rv != 128'b0);
                e    = e - 1;
            end
            case (rm)
                3'd1:       inc = g;
                3'd2, 3'd7: inc = g && (st || mant[0]);
                3'd3:       inc = !s && (g || st);
                3'd4:       inc = s && (g || st);
                3'd5:       inc = g || st;
                default:    inc = 1'b0;
            endcase
            mant = mant + 64'(inc);
            if (mant[53]) begin
                mant = 64'h0010000000000000;
                e    = e + 1;
            end
            if (e >= 2047) begin
                r  = {s, 11'h7FF, 52'b0};
                fl = 5'b10100;
            end else if (e <= 0) begin
                r  = {s, 63'b0};
                fl = 5'b11000;
            end else begin
                r  = {s, e[10:0], mant[51:0]};
                fl = {g || st, 4'b0};
            end
        end
    endfunction

    logic        mBusy, mDone;
    logic [63:0] mRes, pRes;
    logic [4:0]  mRaise, pRaise;
    int          mLeft;
    bit          mSpecial;
    bit          cmpEn = 1'b0;

    // Expected visible outputs: a countdown to done, with starts ignored while one is pending.
    always @(posedge clk) begin
        if (!rst) begin
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mRes   = 64'b0;
            mRaise = 5'b0;
            mLeft  = 0;
        end else begin
            mDone = 1'b0;
            if (mLeft > 0) begin
                mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    mDone  = 1'b1;
                    mBusy  = 1'b0;
                    mRes   = pRes;
                    mRaise = pRaise;
                end
            end else if (start) begin
                modelDiv(A, B, rmode, pRes, pRaise, mSpecial);
                mLeft  = mSpecial ? 1 : 56;
                mBusy  = 1'b1;
                mRes   = 64'b0;
                mRaise = 5'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("model busy", 64'(busy), 64'(mBusy));
            checkOutput("model done", 64'(done), 64'(mDone));
            checkOutput("model res", res, mRes);
            checkOutput("model raise", 64'(raise), 64'(mRaise));
        end
    end

    // Issues one operation, then waits (bounded) for done; the latency is counted in edges after the accepting edge.
    task automatic applyStimulus(input string name, input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                                 input bit useLit, input logic [63:0] expRes, input logic [4:0] expRaise, input int expLat);
        int lat;
        @(negedge clk);
        A     = a;
        B     = b;
        rmode = rm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
        if (useLit) begin
            checkOutput({name, " res"}, res, expRes);
            checkOutput({name, " raise"}, 64'(raise), 64'(expRaise));
        end
    endtask

    initial begin
        int lat;
        int doneCount;
        rst   = 1'b0;
        start = 1'b0;
        A     = 64'b0;
        B     = 64'b0;
        rmode = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset res", res, 64'd0);
        checkOutput("reset raise", 64'(raise), 64'd0);
        cmpEn = 1'b1;

        applyStimulus("1/3 even", 64'h3FF0000000000000, 64'h4008000000000000, 3'd2, 1, 64'h3FD5555555555555, 5'b10000, 56);
        applyStimulus("1/3 away", 64'h3FF0000000000000, 64'h4008000000000000, 3'd5, 1, 64'h3FD5555555555556, 5'b10000, 56);
        applyStimulus("-1/3 -inf", 64'hBFF0000000000000, 64'h4008000000000000, 3'd4, 1, 64'hBFD5555555555556, 5'b10000, 56);
        applyStimulus("1/3 trunc", 64'h3FF0000000000000, 64'h4008000000000000, 3'd0, 1, 64'h3FD5555555555555, 5'b10000, 56);
        applyStimulus("1/3 +inf", 64'h3FF0000000000000, 64'h4008000000000000, 3'd3, 1, 64'h3FD5555555555556, 5'b10000, 56);
        applyStimulus("7/2", 64'h401C000000000000, 64'h4000000000000000, 3'd1, 1, 64'h400C000000000000, 5'b00000, 56);
        applyStimulus("6/2 even", 64'h4018000000000000, 64'h4000000000000000, 3'd2, 1, 64'h4008000000000000, 5'b00000, 56);

        // A start in the done cycle is accepted immediately.
        A     = 64'h3FF0000000000000;
        B     = 64'h0000000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b done low", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("b2b done", 64'(done), 64'd1);
        checkOutput("b2b res", res, 64'h7FF0000000000000);

        applyStimulus("1/0", 64'h3FF0000000000000, 64'h0000000000000000, 3'd2, 1, 64'h7FF0000000000000, 5'b00010, 1);
        applyStimulus("-1/0", 64'hBFF0000000000000, 64'h0000000000000000, 3'd2, 1, 64'hFFF0000000000000, 5'b00010, 1);
        applyStimulus("0/0", 64'h0000000000000000, 64'h0000000000000000, 3'd2, 1, 64'h7FF8000000000000, 5'b00001, 1);
        applyStimulus("snan/1", 64'h7FF0000000000001, 64'h3FF0000000000000, 3'd2, 1, 64'h7FF8000000000000, 5'b00001, 1);
        applyStimulus("qnan/1", 64'h7FF8000000000001, 64'h3FF0000000000000, 3'd2, 1, 64'h7FF8000000000000, 5'b00000, 1);
        applyStimulus("inf/inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 3'd2, 1, 64'h7FF8000000000000, 5'b00001, 1);
        applyStimulus("-inf/2", 64'hFFF0000000000000, 64'h4000000000000000, 3'd2, 1, 64'hFFF0000000000000, 5'b00000, 1);
        applyStimulus("inf/0", 64'h7FF0000000000000, 64'h0000000000000000, 3'd2, 1, 64'h7FF0000000000000, 5'b00000, 1);
        applyStimulus("2/inf", 64'h4000000000000000, 64'h7FF0000000000000, 3'd2, 1, 64'h0000000000000000, 5'b00000, 1);
        applyStimulus("denorm/1", 64'h000FFFFFFFFFFFFF, 64'h3FF0000000000000, 3'd2, 1, 64'h0000000000000000, 5'b00000, 1);
        applyStimulus("1/denorm", 64'h3FF0000000000000, 64'h0000000000000001, 3'd2, 1, 64'h7FF0000000000000, 5'b00010, 1);
        applyStimulus("overflow", 64'h7FE0000000000000, 64'h3FE0000000000000, 3'd2, 1, 64'h7FF0000000000000, 5'b10100, 56);
        applyStimulus("underflow", 64'h0010000000000000, 64'h4000000000000000, 3'd2, 1, 64'h0000000000000000, 5'b11000, 56);

        applyStimulus("1/10 half", 64'h3FF0000000000000, 64'h4024000000000000, 3'd1, 0, 64'b0, 5'b0, 56);
        applyStimulus("1/3 mode7", 64'h3FF0000000000000, 64'h4008000000000000, 3'd7, 0, 64'b0, 5'b0, 56);
        applyStimulus("1/3 mode6", 64'hBFF0000000000000, 64'h4008000000000000, 3'd6, 0, 64'b0, 5'b0, 56);
        applyStimulus("carry", 64'h3FFFFFFFFFFFFFFF, 64'h3FF0000000000001, 3'd5, 0, 64'b0, 5'b0, 56);
        applyStimulus("-7/3 +inf", 64'hC01C000000000000, 64'h4008000000000000, 3'd3, 0, 64'b0, 5'b0, 56);

        // A second start at edge 10 is ignored.
        @(negedge clk);
        A     = 64'h4018000000000000;
        B     = 64'h4000000000000000;
        rmode = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        A     = 64'h3FF0000000000000;
        B     = 64'h4008000000000000;
        rmode = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 10;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignored start latency", 64'(lat), 64'd56);
        checkOutput("ignored start res", res, 64'h4008000000000000);
        checkOutput("ignored start raise", 64'(raise), 64'd0);

        // Reset at edge 20 aborts the operation.
        @(negedge clk);
        A     = 64'h3FF0000000000000;
        B     = 64'h4008000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort res", res, 64'd0);
        checkOutput("abort raise", 64'(raise), 64'd0);
        doneCount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort no done", 64'(doneCount), 64'd0);

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
